// File: rtl/exe_pkg.sv
// Shared execute-stage types: write-back entry layout, default widths and arbitration helpers.
package exe_pkg;

  localparam int EXE_DATA_W = 32;
  localparam int EXE_ROB_W  = 3;
  localparam int EXE_RD_W   = 7;

  typedef struct packed {
    logic [EXE_DATA_W-1:0] data;
    logic [EXE_ROB_W-1:0]  rob_idx;
    logic [EXE_RD_W-1:0]   rd;
  } wb_entry_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Wraps a search index that can exceed the channel count by at most one full lap.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// Result-bus bundle between the functional units (master) and the write-back arbiter (slave).
interface fu_wb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 3,
  parameter int RD_W   = 7
);
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0][ROB_W-1:0]  fu_rob_idx;
  logic [NUM_FU-1:0][RD_W-1:0]   fu_rd;
  logic [NUM_FU-1:0]             fu_ready;

  logic              ex_out_valid;
  logic [DATA_W-1:0] ex_out_data;
  logic [ROB_W-1:0]  ex_out_rob_idx;
  logic [RD_W-1:0]   ex_out_rd;

  logic              wb_out_valid;
  logic [DATA_W-1:0] wb_out_data;
  logic [ROB_W-1:0]  wb_out_rob_idx;
  logic [RD_W-1:0]   wb_out_rd;

  logic overflow;

  modport master (
    output fu_valid, fu_data, fu_rob_idx, fu_rd,
    input  fu_ready,
    input  ex_out_valid, ex_out_data, ex_out_rob_idx, ex_out_rd,
    input  wb_out_valid, wb_out_data, wb_out_rob_idx, wb_out_rd,
    input  overflow
  );

  modport slave (
    input  fu_valid, fu_data, fu_rob_idx, fu_rd,
    output fu_ready,
    output ex_out_valid, ex_out_data, ex_out_rob_idx, ex_out_rd,
    output wb_out_valid, wb_out_data, wb_out_rob_idx, wb_out_rd,
    output overflow
  );
endinterface

// File: rtl/fu_wb_fifo.sv
// Per-channel result buffer: circular FIFO with registered occupancy, wrapping pointers and a clear.
module fu_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 42,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      else      wr_ptr_d = wr_ptr_q;
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      else      rd_ptr_d = rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push && !clr && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fu_wb_arbiter.sv
// Functional-unit write-back arbiter: per-channel buffers, fixed or round-robin grant, 1-cycle WB register.
// Optional flush port is enabled by defining FU_WB_FLUSH_EN.
module fu_wb_arbiter import exe_pkg::*; #(
  parameter int NUM_FU    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int ARB_MODE  = 0,
  parameter int DATA_W    = EXE_DATA_W,
  parameter int ROB_W     = EXE_ROB_W,
  parameter int RD_W      = EXE_RD_W
) (
  input logic clk,
  input logic rst,
`ifdef FU_WB_FLUSH_EN
  input logic flush,
`endif
  fu_wb_arbiter_if.slave bus
);

  localparam int E_W   = DATA_W + ROB_W + RD_W;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int GW    = $clog2(NUM_FU);

  logic [NUM_FU-1:0][E_W-1:0]   in_s, head_s, cand_entry_s;
  logic [NUM_FU-1:0][CNT_W-1:0] count_s;
  logic [NUM_FU-1:0] empty_s, ready_s, accept_s, cand_s, grant_s, push_s, pop_s;
  logic              flush_s, kill_s, ex_valid_s;
  logic [E_W-1:0]    ex_entry_s;
  logic [GW-1:0]     grant_idx_s;

  logic [GW-1:0]  last_grant_q, last_grant_d;
  logic           wb_valid_q, wb_valid_d;
  logic [E_W-1:0] wb_entry_q, wb_entry_d;
  logic           overflow_q, overflow_d;

`ifdef FU_WB_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif
  assign kill_s = rst | flush_s;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_ch
    assign in_s[g] = {bus.fu_data[g], bus.fu_rob_idx[g], bus.fu_rd[g]};
    fu_wb_fifo #(.DEPTH(BUF_DEPTH), .W(E_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush_s),
      .push      (push_s[g]),
      .pop       (pop_s[g]),
      .push_data (in_s[g]),
      .head_data (head_s[g]),
      .count     (count_s[g])
    );
  end

  // Per-channel candidate: buffered head takes precedence over a fresh bypass result.
  always_comb begin
    empty_s      = '0;
    ready_s      = '0;
    accept_s     = '0;
    cand_s       = '0;
    cand_entry_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      empty_s[i]      = (count_s[i] == '0);
      ready_s[i]      = (count_s[i] < CNT_W'(BUF_DEPTH));
      accept_s[i]     = bus.fu_valid[i] & ready_s[i] & ~kill_s;
      cand_s[i]       = empty_s[i] ? accept_s[i] : ~kill_s;
      cand_entry_s[i] = empty_s[i] ? in_s[i] : head_s[i];
    end
  end

  // Grant search, buffer push/pop and next-state for the registered outputs.
  always_comb begin
    logic found;
    int   start;
    int   idx;
    grant_s     = '0;
    grant_idx_s = '0;
    ex_entry_s  = '0;
    push_s      = '0;
    pop_s       = '0;
    found       = 1'b0;
    start       = (ARB_MODE == int'(ARB_RR)) ? int'(last_grant_q) + 1 : 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx          = wrap_idx(start + k, NUM_FU);
      grant_s[idx] = cand_s[idx] & ~found;
      found        = found | cand_s[idx];
    end
    for (int i = 0; i < NUM_FU; i++) begin
      grant_idx_s = grant_idx_s | (grant_s[i] ? GW'(i) : GW'(0));
      ex_entry_s  = ex_entry_s | (grant_s[i] ? cand_entry_s[i] : '0);
      pop_s[i]    = grant_s[i] & ~empty_s[i];
      // A granted bypass is consumed directly; anything else accepted goes behind the head.
      push_s[i]   = accept_s[i] & ~(grant_s[i] & empty_s[i]);
    end
    ex_valid_s   = |grant_s;
    last_grant_d = ex_valid_s ? grant_idx_s : last_grant_q;
    overflow_d   = overflow_q | (|(bus.fu_valid & ~ready_s));
    wb_valid_d   = ex_valid_s;
    wb_entry_d   = ex_entry_s;
  end

  // Arbitration pointer, write-back stage and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GW'(NUM_FU - 1);
      wb_valid_q   <= 1'b0;
      wb_entry_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wb_valid_q   <= wb_valid_d;
      wb_entry_q   <= wb_entry_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.fu_ready       = ready_s;
  assign bus.ex_out_valid   = ex_valid_s;
  assign bus.ex_out_data    = ex_entry_s[E_W-1 -: DATA_W];
  assign bus.ex_out_rob_idx = ex_entry_s[ROB_W+RD_W-1 -: ROB_W];
  assign bus.ex_out_rd      = ex_entry_s[RD_W-1:0];
  assign bus.wb_out_valid   = wb_valid_q;
  assign bus.wb_out_data    = wb_entry_q[E_W-1 -: DATA_W];
  assign bus.wb_out_rob_idx = wb_entry_q[ROB_W+RD_W-1 -: ROB_W];
  assign bus.wb_out_rd      = wb_entry_q[RD_W-1:0];
  assign bus.overflow       = overflow_q;

endmodule

// File: doc/fu_wb_arbiter.md
FU_WB_ARBITER -- requirements
Module: fu_wb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit result channels (2..8).
REQ-002 Parameter BUF_DEPTH, default 2: per-channel result buffer entries (1..4).
REQ-003 Parameter ARB_MODE, default 0: 0 = fixed priority (lowest channel index wins), 1 = round-robin.
REQ-004 Parameter DATA_W / ROB_W / RD_W, defaults 32 / 3 / 7: result, ROB index and physical rd widths.
REQ-005 Ports: clk  in  1  clock; rst  in  1  reset, synchronous active-high; one clock, all state on rising clk.
REQ-006 fu_valid  in  NUM_FU  per-channel result valid.
REQ-007 fu_data / fu_rob_idx / fu_rd  in  NUM_FU x DATA_W / ROB_W / RD_W  per-channel result payload.
REQ-008 fu_ready  out  NUM_FU  channel may present a result this cycle.
REQ-009 ex_out_valid / ex_out_data / ex_out_rob_idx / ex_out_rd  out  1 / DATA_W / ROB_W / RD_W  combinational forwarding of the granted result.
REQ-010 wb_out_valid / wb_out_data / wb_out_rob_idx / wb_out_rd  out  1 / DATA_W / ROB_W / RD_W  registered write-back.
REQ-011 overflow  out  1  sticky error: result presented while fu_ready low.
REQ-012 flush  in  1  discard all pending results (present only under FU_WB_FLUSH_EN).

Function
REQ-013 Per channel, candidate = buffer head if buffer non-empty, else fu_valid/payload directly (bypass).
REQ-014 Exactly one candidate is granted per cycle; granted payload drives ex_out_* in the same cycle; ex_out_valid=0 and payload 0 when no candidate.
REQ-015 ARB_MODE=0: lowest-index valid candidate granted.
REQ-016 ARB_MODE=1: search begins at (last_grant+1) mod NUM_FU; last_grant updates only on a grant.
REQ-017 A granted buffered candidate pops its buffer head; a granted bypass candidate is not stored.
REQ-018 An accepted fu_valid not granted this cycle is pushed into its channel buffer, preserving per-channel order.
REQ-019 With a non-empty buffer, a new fu_valid is always pushed (never bypasses the head); push and pop in the same cycle are both performed.
REQ-020 fu_ready[i] = buffer occupancy < BUF_DEPTH, from registered occupancy (a pop in the current cycle does not raise ready until the next cycle).
REQ-021 fu_valid[i] while fu_ready[i]=0: result dropped, overflow set to 1 and held until reset.
REQ-022 wb_out_* register ex_out_* every cycle: latency 1 cycle from grant, throughput 1 result/cycle.
REQ-023 Occupancy counters and buffer pointers wrap modulo BUF_DEPTH without loss.

Reset
REQ-024 rst=1: all buffers empty, fu_ready all 1, last_grant = NUM_FU-1 (channel 0 first), wb_out_* all 0, overflow 0.
REQ-025 rst mid-operation discards every buffered result; fu_valid during a reset cycle is ignored; ex_out_valid=0 during reset.

Configuration
REQ-026 Macro FU_WB_FLUSH_EN defined: flush port exists; flush=1 empties all buffers, drops inputs that cycle, forces ex_out_valid=0 and wb_out_valid=0 next cycle; last_grant unchanged.
REQ-027 FU_WB_FLUSH_EN undefined: no flush port, no flush logic; all other behaviour identical.

Structure
REQ-028 Shared package exe_pkg holds wb_entry_t (data, rob_idx, rd) and default width constants; ports use wb_entry_t where packed.
REQ-029 One sub-module fu_wb_fifo (BUF_DEPTH-entry, push/pop/count) instantiated per channel; arbitration and WB register live in fu_wb_arbiter.

Verification
REQ-030 Bypass: ch0 valid data=0x11 rob=2 rd=5, others idle -> ex_out same cycle 0x11/2/5, wb_out next cycle, no buffering.
REQ-031 Contention fixed: ch0..3 valid together (0xA0..0xA3), ARB_MODE=0 -> ex_out order 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; fu_ready[1..3] unchanged at BUF_DEPTH=2.
REQ-032 Round-robin: ARB_MODE=1, all four channels valid every cycle for 8 cycles (ready permitting) -> grants 0,1,2,3,0,1,2,3; no channel starved.
REQ-033 Full/overflow: BUF_DEPTH=2, ch0 held busy by ch... fixed-priority load on ch0, ch3 pushes 3 results -> fu_ready[3]=0 after 2, third dropped, overflow=1 until rst.
REQ-034 Order: ch2 pushes 0x1,0x2,0x3 back-to-back under contention -> ch2 results leave in order 0x1,0x2,0x3.
REQ-035 Flush (FU_WB_FLUSH_EN): two buffered entries, flush=1 -> next cycle buffers empty, fu_ready all 1, wb_out_valid=0.
